fetch_prefetch_queue: RTL

//  Parametrised instruction-fetch front end: PC register, PC+step adder and an N-entry prefetch FIFO.

---
 rtl/fetch_prefetch_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: PC register, PC+step adder and a DEPTH-entry prefetch FIFO to decode.
// Optional macro FETCH_BYPASS_EN presents the ROM word straight to decode when the FIFO is empty.
module fetch_prefetch_queue #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 32,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       R,
  input  logic                       fetch_en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [INSTR_W-1:0]         id_instr,
  output logic [ADDR_W-1:0]          id_pc_next,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pcn_mem_q   [DEPTH];
  logic               full, empty, bypass, pop, fifo_pop, fetch, push;

  always_comb begin
    pc_inc = pc_q + ADDR_W'(PC_STEP);
    full   = (count_q == CNT_W'(DEPTH));
    empty  = (count_q == '0);
`ifdef FETCH_BYPASS_EN
    bypass = empty & fetch_en & ~redirect;
`else
    bypass = 1'b0;
`endif
    id_valid   = ~empty | bypass;
    id_instr   = '0;
    id_pc_next = '0;
    if (bypass) begin
      id_instr   = imem_rdata;
      id_pc_next = pc_inc;
    end else if (!empty) begin
      id_instr   = instr_mem_q[rd_ptr_q];
      id_pc_next = pcn_mem_q[rd_ptr_q];
    end
    pop      = id_valid & id_ready;
    fifo_pop = pop & ~empty;
    // A fetch may proceed into a full FIFO when the head leaves in the same cycle.
    fetch    = fetch_en & ~redirect & (~full | fifo_pop);
    // A bypassed word taken by decode this cycle never enters the FIFO.
    push     = fetch & ~(bypass & id_ready);

    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch)    pc_d     = pc_inc;
      if (push)     wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      pc_q     <= ADDR_W'(RESET_PC);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pcn_mem_q[wr_ptr_q]   <= pc_inc;
    end
  end

  assign imem_addr = pc_q;
  assign count     = count_q;

endmodule
